// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared types and defaults for the round-robin demux dispatcher and its picker.
// Pure declarations: no latency, no flow control.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int DEF_N_OUT = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_BURST = 4;

    // Select width for n channels; a single channel still needs one bit to index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// Producer/consumer bundle of the dispatcher; master = traffic side, slave = dispatcher.
// Zero latency wiring; ready/valid handshakes on both the input and the per-channel outputs.
interface demux_rr_dispatcher_if
    import demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int DW    = DEF_DW
);
    localparam int SW = sel_width(N_OUT);

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic [N_OUT-1:0] out_valid;
    logic [DW-1:0]    out_data;
    logic [N_OUT-1:0] out_ready;
    logic [N_OUT-1:0] enable_mask;
    logic [SW-1:0]    sel;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready, enable_mask,
        input  in_ready, out_valid, out_data, sel, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready, enable_mask,
        output in_ready, out_valid, out_data, sel, busy
    );

endinterface

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Round-robin picker: first set mask bit strictly after `last`, wrapping to 0.
// Purely combinational; no flow control.
module rr_pick
    import demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int SW    = sel_width(N_OUT)
) (
    input  logic [N_OUT-1:0] mask,
    input  logic [SW-1:0]    last,
    output logic [SW-1:0]    grant_idx,
    output logic             any
);

    logic [SW-1:0] w_idx;

    // Walk from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        w_idx     = '0;
        for (int k = N_OUT; k >= 1; k--) begin
            w_idx = SW'((int'(last) + k) % N_OUT);
            if (mask[w_idx]) begin
                grant_idx = w_idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin burst dispatcher driving a 1-to-N demux; zero-latency data path, one IDLE cycle between bursts.
// Backpressure: in_ready follows out_ready of the granted channel; a stalled consumer stalls the producer.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int DW    = DEF_DW,
    parameter int BURST = DEF_BURST
) (
    input logic                 clk,
    input logic                 rst_n,
    demux_rr_dispatcher_if.slave bus
);

    localparam int SW = sel_width(N_OUT);
    localparam int BW = $clog2(BURST + 1);

    state_t        r_state;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] r_last;
    logic [BW-1:0] r_beat;
    logic          r_busy;

    logic [SW-1:0] w_grant;
    logic          w_any;
    logic          w_hs;

    rr_pick #(.N_OUT(N_OUT), .SW(SW)) u_pick (
        .mask      (bus.enable_mask),
        .last      (r_last),
        .grant_idx (w_grant),
        .any       (w_any)
    );

    assign w_hs = (r_state == XFER) && bus.in_valid && bus.out_ready[r_sel];

    always_comb begin
        bus.out_valid = '0;
        bus.in_ready  = 1'b0;
        if (r_state == XFER) begin
            bus.out_valid[r_sel] = bus.in_valid;
            bus.in_ready         = bus.out_ready[r_sel];
        end
    end

    assign bus.out_data = bus.in_data;
    assign bus.sel      = r_sel;
    assign bus.busy     = r_busy;

    // Mask is only sampled at the IDLE pick, so a mid-burst mask drop never truncates a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= SW'(N_OUT - 1);
            r_beat  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && w_any) begin
                        r_sel   <= w_grant;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_hs) begin
                        if (r_beat == BW'(BURST - 1)) begin
                            r_last  <= r_sel;
                            r_beat  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: grant order, masking, backpressure, mask drop, reset abort.
module tb_demux_rr_dispatcher;
    import demux_pkg::*;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_rr_dispatcher_if #(.N_OUT(N), .DW(DW)) bus ();

    demux_rr_dispatcher #(.N_OUT(N), .DW(DW), .BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One grant to channel ch; optional stall, mask change or reset at a given beat (-1 = none).
    task automatic burst(input int ch, input int stall_at, input int nstall,
                         input int chg_at, input logic [N-1:0] nmask, input int abort_at);
        logic [N-1:0] oh;
        oh = N'(1 << ch);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        tick();
        for (int b = 0; b < BURST; b++) begin
            if (b == chg_at) bus.enable_mask = nmask;
            if (b == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_out_valid", 32'(bus.out_valid), 0);
                chk("abort_in_ready", 32'(bus.in_ready), 0);
                chk("abort_busy", 32'(bus.busy), 0);
                chk("abort_sel", 32'(bus.sel), 0);
                return;
            end
            if (b == stall_at) begin
                for (int s = 0; s < nstall; s++) begin
                    bus.out_ready[ch] = 1'b0;
                    #1;
                    chk("stall_in_ready", 32'(bus.in_ready), 0);
                    chk("stall_out_valid", 32'(bus.out_valid), 32'(oh));
                    chk("stall_sel", 32'(bus.sel), ch);
                    chk("stall_busy", 32'(bus.busy), 1);
                    tick();
                end
                bus.out_ready = '1;
            end
            word++;
            bus.in_data = word;
            #1;
            chk("xfer_sel", 32'(bus.sel), ch);
            chk("xfer_out_valid", 32'(bus.out_valid), 32'(oh));
            chk("xfer_in_ready", 32'(bus.in_ready), 1);
            chk("xfer_busy", 32'(bus.busy), 1);
            chk("xfer_out_data", 32'(bus.out_data), 32'(word));
            tick();
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_data     = '0;
        bus.out_ready   = '1;
        bus.enable_mask = 4'b1111;
        #12;
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        tick();
        rst_n = 1'b1;

        // First grant ch0, then full rotation of 32 words.
        for (int i = 0; i < 8; i++) burst(i % N, -1, 0, -1, '0, -1);

        bus.enable_mask = 4'b1010;
        burst(1, -1, 0, -1, '0, -1);
        burst(3, -1, 0, -1, '0, -1);
        burst(1, -1, 0, -1, '0, -1);
        burst(3, -1, 0, -1, '0, -1);

        bus.enable_mask = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            chk("nomask_in_ready", 32'(bus.in_ready), 0);
            chk("nomask_busy", 32'(bus.busy), 0);
            tick();
        end

        // Only ch2 eligible after last=3; stall after two beats for five cycles.
        bus.enable_mask = 4'b0100;
        burst(2, 2, 5, -1, '0, -1);

        // ch1 granted, loses its enable after two beats, still finishes; next pick skips to ch2.
        bus.enable_mask = 4'b0010;
        burst(1, -1, 0, 2, 4'b1101, -1);
        burst(2, -1, 0, -1, '0, -1);

        bus.enable_mask = 4'b1111;
        burst(3, -1, 0, -1, '0, 2);
        tick();
        rst_n = 1'b1;
        burst(0, -1, 0, -1, '0, -1);
        chk("final_idle_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Controller that shares one input word stream across N_OUT downstream consumers.
- Drives the select of a 1-to-N_OUT demultiplexer.
- Grants channels round-robin, in fixed-length bursts of BURST words.
- Sits between a single producer and N_OUT consumers; all sides use valid/ready handshakes.

Parameters:
N_OUT, 4, number of output channels (>=2)
DW, 8, data word width
BURST, 4, words sent to a channel per grant (>=1)
SW, $clog2(N_OUT), select width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  producer has a word
in_data  input  DW  producer word
in_ready  output  1  dispatcher accepts the word this cycle
out_valid  output  N_OUT  one-hot valid to consumers
out_data  output  DW  shared data bus to all consumers
out_ready  input  N_OUT  per-consumer ready
enable_mask  input  N_OUT  channels eligible for grants
sel  output  SW  current demux select (registered)
busy  output  1  high while a burst is in progress

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, sel=0, last=N_OUT-1 (so the first grant goes to ch0), beat=0.
  - busy=0, out_valid=0, in_ready=0.
- FSM has two states, IDLE and XFER.
- IDLE:
  - in_ready=0 and out_valid=0.
  - If in_valid=1 and enable_mask!=0: pick the first enabled channel strictly after `last`, searching upward with wrap-around from N_OUT-1 to 0.
  - Register the pick into sel, set beat=0, busy=1, go to XFER.
  - If enable_mask==0: stay in IDLE and never grant.
  - in_valid alone does not trigger a grant.
- XFER:
  - out_valid[sel]=in_valid; all other bits are 0.
  - in_ready=out_ready[sel]. Combinational; no registers in the data path.
  - out_data=in_data at all times.
  - A handshake is in_valid & out_ready[sel]. Each handshake increments beat.
  - On the handshake where beat==BURST-1: set last=sel, beat=0, busy=0, go to IDLE.
  - With no handshake, state and beat hold.
- Latency:
  - Zero cycles in-to-out within a burst.
  - One arbitration cycle (IDLE) between bursts.
  - Peak throughput is BURST/(BURST+1) words per cycle.
- Mask changes mid-burst: the current burst completes even if enable_mask[sel] drops. The new mask applies only at the next IDLE pick.
- If only one channel is enabled, it is re-granted every burst, with one idle cycle between bursts.
- A consumer that holds out_ready=0 stalls the producer indefinitely. No timeout.
- sel changes only on the IDLE->XFER transition.
- Asserting rst_n mid-burst aborts the burst immediately and returns all outputs to reset values. Words already handshaked are not replayed.
- beat is $clog2(BURST+1) bits wide and never exceeds BURST-1.

Decomposition:
- Package demux_pkg holds:
  - the state enum (IDLE, XFER);
  - a function computing SW from N_OUT;
  - default parameter constants.
- One combinational sub-module, rr_pick:
  - inputs: mask[N_OUT], last[SW];
  - outputs: grant_idx[SW], any.
  - It is reused by other arbiters in the codebase.

Test Plan:
- Reset and first grant: reset with mask=4'b1111, in_valid=1, all out_ready=1 -> sel=0, out_valid=4'b0001 for 4 consecutive cycles, then 1 idle cycle, then sel=1.
- Full rotation: stream 32 words, all ready, all enabled -> grant order 0,1,2,3,0,1,2,3. Each channel receives in_data values in order; 8 idle cycles total.
- Masking: mask=4'b1010 -> grants alternate 1,3,1,3. mask=0 -> in_ready stays 0 and busy=0 for 20 cycles.
- Backpressure: out_ready[2]=0 for 5 cycles mid-burst on ch2 -> in_ready=0, beat holds, no data is lost, and the burst finishes with exactly 4 handshakes.
- Mask drop mid-burst: clear enable_mask[1] after 2 beats on ch1 -> ch1 still receives 4 words, and the next grant skips to ch2.
- Reset mid-burst: assert rst_n=0 after beat 2 on ch3 -> out_valid=0, in_ready=0, busy=0 asynchronously. After release, the first grant is ch0.
